// File: rtl/conv1_stream_ctrl.sv
// rtl/conv1_stream_ctrl.sv - conv1 stage sequencer: replays the input BRAM into the window buffer once per output channel
module conv1_stream_ctrl #(
  parameter int IN_LEN   = 24,
  parameter int KSIZE    = 2,
  parameter int OUT_CH   = 4,
  parameter int PIPE_LAT = 2,
  parameter int ADDR_W   = 5,
  parameter int CH_W     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  output logic               busy,
  output logic               done,
  output logic               mem_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic signed [15:0] mem_rdata,
  output logic               buf_rst,
  output logic               buf_start,
  output logic signed [15:0] buf_idata,
  input  logic               win_valid,
  output logic [CH_W-1:0]    ch_idx,
  output logic [7:0]         win_cnt,
  output logic               ch_done,
  output logic               cnt_err
);

  localparam int EXP_WIN = IN_LEN - KSIZE + 1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    NEXT,
    DONE
  } state_t;

  state_t state, state_next;

  // Shared counter: stream address in STREAM, drain cycle in DRAIN.
  logic [ADDR_W-1:0] cnt;
  logic              mem_en_d;
  logic [7:0]        win_cnt_next;
  logic              last_ch;

  assign last_ch = (ch_idx == CH_W'(OUT_CH - 1));

  always_comb begin
    win_cnt_next = win_cnt;
    if (busy && win_valid && (win_cnt != 8'hFF)) begin
      win_cnt_next = win_cnt + 8'd1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (go) state_next = CLEAR;
      CLEAR:   state_next = STREAM;
      STREAM:  if (cnt == ADDR_W'(IN_LEN - 1)) state_next = DRAIN;
      DRAIN:   if (cnt == ADDR_W'(PIPE_LAT)) state_next = NEXT;
      NEXT:    state_next = last_ch ? DONE : CLEAR;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Outputs are registered from the current state, so each one trails its state by a cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_en    <= 1'b0;
      mem_addr  <= '0;
      buf_rst   <= 1'b1;
      buf_start <= 1'b0;
      buf_idata <= '0;
      ch_idx    <= '0;
      win_cnt   <= '0;
      ch_done   <= 1'b0;
      cnt_err   <= 1'b0;
      cnt       <= '0;
      mem_en_d  <= 1'b0;
    end else begin
      done      <= (state == DONE);
      ch_done   <= (state == NEXT);
      buf_rst   <= (state == CLEAR);
      mem_en    <= (state == STREAM);
      mem_addr  <= (state == STREAM) ? cnt : '0;
      mem_en_d  <= mem_en;
      // BRAM data lands the cycle after mem_en; start and data move to the buffer together.
      buf_start <= mem_en_d;
      buf_idata <= mem_en_d ? mem_rdata : '0;
      win_cnt   <= (state == CLEAR) ? 8'd0 : win_cnt_next;

      case (state)
        STREAM:  cnt <= (cnt == ADDR_W'(IN_LEN - 1)) ? '0 : cnt + 1'b1;
        DRAIN:   cnt <= cnt + 1'b1;
        default: cnt <= '0;
      endcase

      if (state == IDLE && go) begin
        busy    <= 1'b1;
        ch_idx  <= '0;
        cnt_err <= 1'b0;
      end

      if (state == NEXT) begin
        if (win_cnt_next != 8'(EXP_WIN)) cnt_err <= 1'b1;
        if (!last_ch) ch_idx <= ch_idx + CH_W'(1);
      end

      if (state == DONE) busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv1_stream_ctrl.sv
// tb/tb_conv1_stream_ctrl.sv - scoreboard bench for conv1_stream_ctrl with BRAM and window-buffer models
module tb_conv1_stream_ctrl;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               go  = 1'b0;
  logic               busy, done, mem_en, buf_rst, buf_start, ch_done, cnt_err;
  logic [4:0]         mem_addr;
  logic signed [15:0] mem_rdata = '0;
  logic signed [15:0] buf_idata;
  logic               win_valid = 1'b0;
  logic [1:0]         ch_idx;
  logic [7:0]         win_cnt;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic drop = 1'b0;
  int   bcnt = 0;

  typedef struct {
    int cyc;
    int a;
    int b;
    int c;
  } ev_t;

  ev_t q_start[$];
  ev_t q_brst[$];
  ev_t q_chd[$];
  ev_t q_done[$];

  conv1_stream_ctrl dut (
    .clk(clk), .rst(rst), .go(go), .busy(busy), .done(done),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .buf_rst(buf_rst), .buf_start(buf_start), .buf_idata(buf_idata),
    .win_valid(win_valid), .ch_idx(ch_idx), .win_cnt(win_cnt),
    .ch_done(ch_done), .cnt_err(cnt_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // BRAM returns addr*3 one cycle after the read enable.
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= 16'(int'(mem_addr) * 3);
  end

  // Two-tap window buffer: a window is valid from the second sample on; drop optionally loses one in channel 2.
  always @(posedge clk) begin
    if (buf_rst) begin
      bcnt      <= 0;
      win_valid <= 1'b0;
    end else if (buf_start) begin
      bcnt      <= bcnt + 1;
      win_valid <= (bcnt >= 1) && !(drop && ch_idx == 2'd2 && bcnt == 5);
    end else begin
      win_valid <= 1'b0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_mem_en"}, int'(mem_en), 0);
    chk({tag, "_mem_addr"}, int'(mem_addr), 0);
    chk({tag, "_buf_rst"}, int'(buf_rst), 1);
    chk({tag, "_buf_start"}, int'(buf_start), 0);
    chk({tag, "_buf_idata"}, int'(buf_idata), 0);
    chk({tag, "_ch_idx"}, int'(ch_idx), 0);
    chk({tag, "_win_cnt"}, int'(win_cnt), 0);
    chk({tag, "_ch_done"}, int'(ch_done), 0);
    chk({tag, "_cnt_err"}, int'(cnt_err), 0);
  endtask

  // Expected events of a run whose go was sampled at edge g; only those visible at or before lim.
  task automatic push_run(input int g, input int lim, input bit drp);
    ev_t e;
    for (int c = 0; c < 4; c++) begin
      e = '{g + 1 + 29 * c, 0, 0, 0};
      if (e.cyc <= lim) q_brst.push_back(e);
      for (int i = 0; i < 24; i++) begin
        e = '{g + 4 + 29 * c + i, 3 * i, c, 0};
        if (e.cyc <= lim) q_start.push_back(e);
      end
      e = '{g + 29 * (c + 1), (c < 3) ? c + 1 : 3, (drp && c >= 2) ? 1 : 0, (drp && c == 2) ? 22 : 23};
      if (e.cyc <= lim) q_chd.push_back(e);
    end
    e = '{g + 117, 3, drp ? 1 : 0, 0};
    if (e.cyc <= lim) q_done.push_back(e);
  endtask

  task automatic pulse_go(output int g);
    @(negedge clk);
    go = 1'b1;
    g  = cyc + 1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  function automatic int pending();
    return q_start.size() + q_brst.size() + q_chd.size() + q_done.size();
  endfunction

  always @(negedge clk) begin
    ev_t e;
    if (buf_start) begin
      if (q_start.size() == 0) chk("start_unexpected", cyc, -1);
      else begin
        e = q_start.pop_front();
        chk("start_cyc", cyc, e.cyc);
        chk("start_data", int'(buf_idata), e.a);
        chk("start_ch", int'(ch_idx), e.b);
      end
    end
    if (buf_rst && busy) begin
      if (q_brst.size() == 0) chk("bufrst_unexpected", cyc, -1);
      else begin
        e = q_brst.pop_front();
        chk("bufrst_cyc", cyc, e.cyc);
      end
    end
    if (ch_done) begin
      if (q_chd.size() == 0) chk("chdone_unexpected", cyc, -1);
      else begin
        e = q_chd.pop_front();
        chk("chdone_cyc", cyc, e.cyc);
        chk("chdone_ch_idx", int'(ch_idx), e.a);
        chk("chdone_cnt_err", int'(cnt_err), e.b);
        chk("chdone_win_cnt", int'(win_cnt), e.c);
      end
    end
    if (done) begin
      if (q_done.size() == 0) chk("done_unexpected", cyc, -1);
      else begin
        e = q_done.pop_front();
        chk("done_cyc", cyc, e.cyc);
        chk("done_ch_idx", int'(ch_idx), e.a);
        chk("done_cnt_err", int'(cnt_err), e.b);
        chk("done_busy", int'(busy), 0);
      end
    end
  end

  initial begin
    int g;
    int g2;
    int offs[4] = '{3, 40, 90, 117};

    repeat (3) @(negedge clk);
    check_reset("init");
    rst = 1'b0;

    // Plain run: timing, data sequence, channel indices, no error.
    pulse_go(g);
    chk("t1_busy_start", int'(busy), 1);
    push_run(g, 1 << 30, 1'b0);
    wait_until(g + 116);
    chk("t1_busy_last", int'(busy), 1);
    wait_until(g + 117);
    chk("t1_busy_fall", int'(busy), 0);
    wait_until(g + 125);
    chk("t1_pending", pending(), 0);
    chk("t1_cnt_err", int'(cnt_err), 0);

    // Dropped window in channel 2 sets a sticky error.
    drop = 1'b1;
    pulse_go(g);
    push_run(g, 1 << 30, 1'b1);
    wait_until(g + 125);
    drop = 1'b0;
    chk("t3_err_sticky", int'(cnt_err), 1);
    chk("t3_pending", pending(), 0);

    // go spam during busy and on the DONE cycle is ignored; go clears the error.
    pulse_go(g);
    chk("t4_err_cleared", int'(cnt_err), 0);
    push_run(g, 1 << 30, 1'b0);
    for (int k = 0; k < 4; k++) begin
      wait_until(g + offs[k] - 1);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
    end
    chk("t4_busy_after_done", int'(busy), 0);
    wait_until(g + 130);
    chk("t4_no_restart", int'(busy), 0);
    chk("t4_pending", pending(), 0);

    // Reset in channel 1 STREAM aborts the run.
    pulse_go(g);
    push_run(g, g + 39, 1'b0);
    wait_until(g + 39);
    rst = 1'b1;
    @(negedge clk);
    check_reset("t5");
    rst = 1'b0;
    wait_until(g + 170);
    chk("t5_idle", int'(busy), 0);
    chk("t5_pending", pending(), 0);
    pulse_go(g);
    push_run(g, 1 << 30, 1'b0);
    wait_until(g + 125);
    chk("t5_rerun_pending", pending(), 0);

    // Back-to-back runs: go the cycle after done.
    pulse_go(g);
    push_run(g, 1 << 30, 1'b0);
    wait_until(g + 117);
    chk("t6_busy_gap", int'(busy), 0);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    g2 = g + 118;
    chk("t6_busy_again", int'(busy), 1);
    push_run(g2, 1 << 30, 1'b0);
    wait_until(g2 + 125);
    chk("t6_pending", pending(), 0);
    chk("t6_idle", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
